dhcp_vlg_cli_fsm: RTL and testbench
===================================

Name: dhcp_vlg_cli_fsm

Overview:
DHCP client control state machine. It sits directly upstream of the DHCP transmit assembler and drives its per-message descriptor: message type, xid, requested IP, server ID and option-present mask. It consumes parsed fields from the DHCP receive parser and runs the DISCOVER→OFFER→REQUEST→ACK exchange with timeouts and retries. When the exchange completes it reports the bound IP address to the IPv4 stack.

Parameters:
- TIMEOUT_TICKS, 1250000, clk cycles to wait for an OFFER or ACK (10 ms at 125 MHz).
- RETRIES, 3, maximum transmissions per phase before FAIL.
- MAC_ADDR, 48'h0, local MAC; used as chaddr and client-ID.
- XID_SEED, 32'hA5A5_5A5A, non-zero LFSR seed.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; begin acquisition, or re-acquisition from BOUND/FAIL
- tx_val  out  1  one-cycle pulse; descriptor valid to TX assembler
- tx_msg_type  out  8  1=DISCOVER, 3=REQUEST
- tx_xid  out  32  transaction ID
- tx_req_ip  out  32  requested IP (option 50)
- tx_srv_id  out  32  server identifier (option 54)
- tx_opt_pres  out  7  option mask, bit0=msg_type … bit6=end
- tx_done  in  1  pulse; TX assembler emitted its last byte
- rx_val  in  1  pulse; parsed reply valid
- rx_msg_type  in  8  2=OFFER, 5=ACK, 6=NAK
- rx_xid  in  32  reply xid
- rx_yiaddr  in  32  offered/assigned IP
- rx_srv_id  in  32  server identifier from reply
- ip_addr  out  32  bound IP; 0 when not bound
- ready  out  1  high in BOUND
- fail  out  1  high in FAIL
- busy  out  1  high in any state other than IDLE/BOUND/FAIL

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0, retry counter 0, timer 0, LFSR = XID_SEED.
- States: IDLE, DISC_TX, DISC_WAIT_TX, OFFER_WAIT, REQ_TX, REQ_WAIT_TX, ACK_WAIT, BOUND, FAIL.
- IDLE/BOUND/FAIL + start → DISC_TX. On this transition: retry counter cleared, ready/fail cleared, ip_addr cleared. start is ignored while busy.
- DISC_TX:
  - Latch tx_xid ← LFSR.
  - Pulse tx_val for exactly 1 cycle with msg_type=1, req_ip=0, srv_id=0, opt_pres=7'b1111001 (msg_type, host, domain, fqdn, end).
  - Increment retry counter; go to DISC_WAIT_TX.
- DISC_WAIT_TX: on tx_done → OFFER_WAIT with timer=0.
- OFFER_WAIT:
  - rx_val, type 2, rx_xid==tx_xid → latch tx_req_ip←rx_yiaddr and tx_srv_id←rx_srv_id; clear retry counter; go to REQ_TX.
  - timer==TIMEOUT_TICKS-1 → DISC_TX if retries<RETRIES, else FAIL.
  - New xid on every DISCOVER retransmission.
- REQ_TX: pulse tx_val with msg_type=3, same xid, opt_pres=7'b1111111; increment retry counter; go to REQ_WAIT_TX.
- REQ_WAIT_TX: on tx_done → ACK_WAIT with timer=0.
- ACK_WAIT:
  - type 5 with matching xid → BOUND; ip_addr←rx_yiaddr.
  - type 6 with matching xid → DISC_TX; retry counter cleared.
  - Timeout → REQ_TX if retries<RETRIES, else FAIL.
- rx_val with wrong xid, wrong type, or in a non-wait state: ignored, no state change.
- rx_val and timeout in the same cycle: the rx match wins.
- Timer is 32-bit saturating and runs only in the wait states.
- LFSR: 32-bit Galois, taps 32,22,2,1, advances every cycle. It never holds zero; a zero seed is replaced by 1.
- tx_* descriptor fields hold stable from the tx_val pulse until the next tx_val pulse.
- Latency: start → tx_val is 2 cycles.

Optional Feature:
- Macro: DHCP_RAPID_COMMIT_EN.
- Defined: the DISCOVER sets an 8th opt_pres bit (option 80, rapid commit), so tx_opt_pres widens to 8. In OFFER_WAIT, a matching ACK goes directly to BOUND.
- Undefined: tx_opt_pres is 7 bits and an ACK in OFFER_WAIT is ignored.

Decomposition:
- dhcp_vlg_pkg gets:
  - message-type constants: DHCP_MSG_DISCOVER=1, OFFER=2, REQUEST=3, ACK=5, NAK=6;
  - state enum dhcp_cli_fsm_t;
  - opt_pres mask constants.
- One sub-module: dhcp_vlg_xid_lfsr, holding the free-running LFSR with seed guard.

Test Plan:
- Normal exchange (TIMEOUT_TICKS=100): start → DISCOVER tx_val with type 1; tx_done; OFFER with matching xid and yiaddr=192.168.1.50 → REQUEST carries req_ip=C0A80132; ACK → ready=1 and ip_addr=C0A80132.
- Mismatched xid: OFFER with xid=tx_xid^1 → ignored; after 100 cycles a DISCOVER is re-sent with a new xid.
- Retries exhausted: RETRIES=3, no replies → exactly 3 DISCOVER pulses, then fail=1 and busy=0.
- NAK in ACK_WAIT → a DISCOVER follows within 2 cycles with a fresh xid; ready stays 0.
- Same-cycle collision: matching OFFER on the exact timeout cycle → REQ_TX is taken, no DISCOVER.
- Reset mid-operation: rst_n low during ACK_WAIT → all outputs 0 immediately (async). After release, start → a fresh DISCOVER is sent.

Source files
------------

// File: rtl/dhcp_vlg_pkg.sv
// Shared constants, state encoding and XID LFSR step for the DHCP client FSM.
// DHCP_RAPID_COMMIT_EN widens the option-present mask to carry option 80.
package dhcp_vlg_pkg;

  localparam logic [7:0] DHCP_MSG_DISCOVER = 8'd1;
  localparam logic [7:0] DHCP_MSG_OFFER    = 8'd2;
  localparam logic [7:0] DHCP_MSG_REQUEST  = 8'd3;
  localparam logic [7:0] DHCP_MSG_ACK      = 8'd5;
  localparam logic [7:0] DHCP_MSG_NAK      = 8'd6;

  // opt_pres bits: 0 msg_type, 1 req_ip, 2 srv_id, 3 host, 4 domain, 5 fqdn, 6 end, 7 rapid commit
`ifdef DHCP_RAPID_COMMIT_EN
  localparam int OPT_W = 8;
  localparam logic [OPT_W-1:0] OPT_DISCOVER = 8'b1111_1001;
  localparam logic [OPT_W-1:0] OPT_REQUEST  = 8'b0111_1111;
`else
  localparam int OPT_W = 7;
  localparam logic [OPT_W-1:0] OPT_DISCOVER = 7'b111_1001;
  localparam logic [OPT_W-1:0] OPT_REQUEST  = 7'b111_1111;
`endif

  typedef enum logic [3:0] {
    CLI_IDLE         = 4'd0,
    CLI_DISC_TX      = 4'd1,
    CLI_DISC_WAIT_TX = 4'd2,
    CLI_OFFER_WAIT   = 4'd3,
    CLI_REQ_TX       = 4'd4,
    CLI_REQ_WAIT_TX  = 4'd5,
    CLI_ACK_WAIT     = 4'd6,
    CLI_BOUND        = 4'd7,
    CLI_FAIL         = 4'd8
  } dhcp_cli_fsm_t;

  // Galois form of x^32 + x^22 + x^2 + x + 1, shifting toward bit 0
  localparam logic [31:0] XID_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? XID_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/dhcp_vlg_cli_fsm_if.sv
// Descriptor bus to the DHCP TX assembler and parsed-reply bus from the RX parser.
// tx_opt_pres width follows DHCP_RAPID_COMMIT_EN through the package.
interface dhcp_vlg_cli_fsm_if;
  import dhcp_vlg_pkg::*;

  logic             tx_val;
  logic [7:0]       tx_msg_type;
  logic [31:0]      tx_xid;
  logic [31:0]      tx_req_ip;
  logic [31:0]      tx_srv_id;
  logic [OPT_W-1:0] tx_opt_pres;
  logic             tx_done;

  logic             rx_val;
  logic [7:0]       rx_msg_type;
  logic [31:0]      rx_xid;
  logic [31:0]      rx_yiaddr;
  logic [31:0]      rx_srv_id;

  modport master (
    output tx_val, tx_msg_type, tx_xid, tx_req_ip, tx_srv_id, tx_opt_pres,
    input  tx_done,
    input  rx_val, rx_msg_type, rx_xid, rx_yiaddr, rx_srv_id
  );

  modport slave (
    input  tx_val, tx_msg_type, tx_xid, tx_req_ip, tx_srv_id, tx_opt_pres,
    output tx_done,
    output rx_val, rx_msg_type, rx_xid, rx_yiaddr, rx_srv_id
  );

endinterface

// File: rtl/dhcp_vlg_xid_lfsr.sv
// Free-running 32-bit Galois LFSR supplying transaction IDs; a zero seed is forced to 1.
module dhcp_vlg_xid_lfsr
  import dhcp_vlg_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hA5A5_5A5A
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] lfsr_o
);

  localparam logic [31:0] SEED_G = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED_G;
    else        lfsr_q <= lfsr_step(lfsr_q);
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/dhcp_vlg_cli_fsm.sv
// DHCP client control FSM: DISCOVER/OFFER/REQUEST/ACK exchange with timeouts and retries.
// DHCP_RAPID_COMMIT_EN: DISCOVER carries option 80 and a matching ACK in OFFER_WAIT binds directly.
module dhcp_vlg_cli_fsm
  import dhcp_vlg_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = 1250000,
  parameter int unsigned RETRIES       = 3,
  parameter logic [47:0] MAC_ADDR      = 48'h0,
  parameter logic [31:0] XID_SEED      = 32'hA5A5_5A5A
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  dhcp_vlg_cli_fsm_if.master tx_rx,
  output logic [31:0]        ip_addr,
  output logic               ready,
  output logic               fail,
  output logic               busy
);

  localparam int RW = (RETRIES < 2) ? 1 : $clog2(RETRIES + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(RETRIES);
  localparam logic [31:0]   TO_LAST   = 32'(TIMEOUT_TICKS - 1);

  localparam logic [3:0] S_IDLE         = CLI_IDLE;
  localparam logic [3:0] S_DISC_TX      = CLI_DISC_TX;
  localparam logic [3:0] S_DISC_WAIT_TX = CLI_DISC_WAIT_TX;
  localparam logic [3:0] S_OFFER_WAIT   = CLI_OFFER_WAIT;
  localparam logic [3:0] S_REQ_TX       = CLI_REQ_TX;
  localparam logic [3:0] S_REQ_WAIT_TX  = CLI_REQ_WAIT_TX;
  localparam logic [3:0] S_ACK_WAIT     = CLI_ACK_WAIT;
  localparam logic [3:0] S_BOUND        = CLI_BOUND;
  localparam logic [3:0] S_FAIL         = CLI_FAIL;

  // chaddr/client-ID must be a unicast hardware address
  if (MAC_ADDR[40]) begin : g_mac_chk
    $error("dhcp_vlg_cli_fsm: MAC_ADDR must be unicast");
  end

  logic [3:0]       state_q, state_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [31:0]      timer_q, timer_d;
  logic             tx_val_q, tx_val_d;
  logic [7:0]       msg_q, msg_d;
  logic [31:0]      xid_q, xid_d;
  logic [31:0]      req_ip_q, req_ip_d;
  logic [31:0]      srv_id_q, srv_id_d;
  logic [OPT_W-1:0] opt_q, opt_d;
  logic [31:0]      offer_ip_q, offer_ip_d;
  logic [31:0]      offer_srv_q, offer_srv_d;
  logic [31:0]      ip_q, ip_d;
  logic [31:0]      lfsr;

  logic rx_hit, offer_hit, ack_hit, nak_hit, timeout;

  dhcp_vlg_xid_lfsr #(.SEED(XID_SEED)) u_xid_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .lfsr_o (lfsr)
  );

  assign rx_hit    = tx_rx.rx_val && (tx_rx.rx_xid == xid_q);
  assign offer_hit = rx_hit && (tx_rx.rx_msg_type == DHCP_MSG_OFFER);
  assign ack_hit   = rx_hit && (tx_rx.rx_msg_type == DHCP_MSG_ACK);
  assign nak_hit   = rx_hit && (tx_rx.rx_msg_type == DHCP_MSG_NAK);
  assign timeout   = (timer_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    tx_val_d    = 1'b0;
    msg_d       = msg_q;
    xid_d       = xid_q;
    req_ip_d    = req_ip_q;
    srv_id_d    = srv_id_q;
    opt_d       = opt_q;
    offer_ip_d  = offer_ip_q;
    offer_srv_d = offer_srv_q;
    ip_d        = ip_q;

    if ((state_q == S_OFFER_WAIT || state_q == S_ACK_WAIT) && timer_q != 32'hFFFF_FFFF)
      timer_d = timer_q + 32'd1;

    case (state_q)
      S_IDLE, S_BOUND, S_FAIL: begin
        if (start) begin
          state_d = S_DISC_TX;
          retry_d = '0;
          ip_d    = '0;
        end
      end
      S_DISC_TX: begin
        tx_val_d = 1'b1;
        xid_d    = lfsr;
        msg_d    = DHCP_MSG_DISCOVER;
        req_ip_d = '0;
        srv_id_d = '0;
        opt_d    = OPT_DISCOVER;
        retry_d  = retry_q + 1'b1;
        state_d  = S_DISC_WAIT_TX;
      end
      S_DISC_WAIT_TX: begin
        if (tx_rx.tx_done) begin
          state_d = S_OFFER_WAIT;
          timer_d = '0;
        end
      end
      S_OFFER_WAIT: begin
        // a reply landing on the timeout cycle takes priority over the timeout
        if (offer_hit) begin
          offer_ip_d  = tx_rx.rx_yiaddr;
          offer_srv_d = tx_rx.rx_srv_id;
          retry_d     = '0;
          state_d     = S_REQ_TX;
        end
`ifdef DHCP_RAPID_COMMIT_EN
        else if (ack_hit) begin
          ip_d    = tx_rx.rx_yiaddr;
          state_d = S_BOUND;
        end
`endif
        else if (timeout) begin
          state_d = (retry_q < RETRY_MAX) ? S_DISC_TX : S_FAIL;
        end
      end
      S_REQ_TX: begin
        tx_val_d = 1'b1;
        msg_d    = DHCP_MSG_REQUEST;
        req_ip_d = offer_ip_q;
        srv_id_d = offer_srv_q;
        opt_d    = OPT_REQUEST;
        retry_d  = retry_q + 1'b1;
        state_d  = S_REQ_WAIT_TX;
      end
      S_REQ_WAIT_TX: begin
        if (tx_rx.tx_done) begin
          state_d = S_ACK_WAIT;
          timer_d = '0;
        end
      end
      S_ACK_WAIT: begin
        if (ack_hit) begin
          ip_d    = tx_rx.rx_yiaddr;
          state_d = S_BOUND;
        end else if (nak_hit) begin
          retry_d = '0;
          state_d = S_DISC_TX;
        end else if (timeout) begin
          state_d = (retry_q < RETRY_MAX) ? S_REQ_TX : S_FAIL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      retry_q     <= '0;
      timer_q     <= '0;
      tx_val_q    <= 1'b0;
      msg_q       <= '0;
      xid_q       <= '0;
      req_ip_q    <= '0;
      srv_id_q    <= '0;
      opt_q       <= '0;
      offer_ip_q  <= '0;
      offer_srv_q <= '0;
      ip_q        <= '0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      tx_val_q    <= tx_val_d;
      msg_q       <= msg_d;
      xid_q       <= xid_d;
      req_ip_q    <= req_ip_d;
      srv_id_q    <= srv_id_d;
      opt_q       <= opt_d;
      offer_ip_q  <= offer_ip_d;
      offer_srv_q <= offer_srv_d;
      ip_q        <= ip_d;
    end
  end

  assign tx_rx.tx_val      = tx_val_q;
  assign tx_rx.tx_msg_type = msg_q;
  assign tx_rx.tx_xid      = xid_q;
  assign tx_rx.tx_req_ip   = req_ip_q;
  assign tx_rx.tx_srv_id   = srv_id_q;
  assign tx_rx.tx_opt_pres = opt_q;

  assign ip_addr = ip_q;
  assign ready   = (state_q == S_BOUND);
  assign fail    = (state_q == S_FAIL);
  assign busy    = !(state_q == S_IDLE || state_q == S_BOUND || state_q == S_FAIL);

endmodule

// File: tb/tb_dhcp_vlg_cli_fsm.sv
// Bench for dhcp_vlg_cli_fsm: randomized exchanges against timing/value rules of the DHCP client.
// Expected option masks follow DHCP_RAPID_COMMIT_EN.
module tb_dhcp_vlg_cli_fsm;
  import dhcp_vlg_pkg::*;

  localparam int unsigned T    = 100;
  localparam int unsigned NRET = 3;
  localparam logic [31:0] SEED = 32'hA5A5_5A5A;
  localparam logic [31:0] YI   = 32'hC0A8_0132;
`ifdef DHCP_RAPID_COMMIT_EN
  localparam logic [7:0] EXP_OPT_DISC = 8'hF9;
`else
  localparam logic [7:0] EXP_OPT_DISC = 8'h79;
`endif
  localparam logic [7:0] EXP_OPT_REQ = 8'h7F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ip_addr;
  logic        ready, fail, busy;

  dhcp_vlg_cli_fsm_if bus ();

  dhcp_vlg_cli_fsm #(
    .TIMEOUT_TICKS (T),
    .RETRIES       (NRET),
    .MAC_ADDR      (48'h02_00_5E_00_00_01),
    .XID_SEED      (SEED)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .tx_rx   (bus),
    .ip_addr (ip_addr),
    .ready   (ready),
    .fail    (fail),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_disc = 0;
  logic        prev_tx = 1'b0;
  logic [31:0] m_lfsr, m_xid_prev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference XID sequence: polynomial x^32+x^22+x^2+x+1, one step per clock since reset
  function automatic logic [31:0] ref_next(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr     <= SEED;
      m_xid_prev <= SEED;
    end else begin
      m_xid_prev <= m_lfsr;
      m_lfsr     <= ref_next(m_lfsr);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n && bus.tx_val) begin
      chk("tx_val_one_cycle", 64'(prev_tx), 64'd0);
      if (bus.tx_msg_type == DHCP_MSG_DISCOVER) begin
        chk("disc_xid_seq", 64'(bus.tx_xid), 64'(m_xid_prev));
        n_disc++;
      end
    end
    prev_tx = bus.tx_val;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int max_cyc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.tx_val && n < max_cyc);
    chk("tx_val_seen", 64'(bus.tx_val), 64'd1);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_tx_done(input int gap);
    repeat (gap) tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] mt, input logic [31:0] xid,
                         input logic [31:0] yi, input logic [31:0] srv);
    bus.rx_val      = 1'b1;
    bus.rx_msg_type = mt;
    bus.rx_xid      = xid;
    bus.rx_yiaddr   = yi;
    bus.rx_srv_id   = srv;
    tick();
    bus.rx_val    = 1'b0;
    bus.rx_xid    = $urandom;
    bus.rx_yiaddr = $urandom;
  endtask

  task automatic check_disc(input string tag);
    chk({tag, "_type"},   64'(bus.tx_msg_type), 64'(DHCP_MSG_DISCOVER));
    chk({tag, "_opt"},    64'(bus.tx_opt_pres), 64'(EXP_OPT_DISC));
    chk({tag, "_req_ip"}, 64'(bus.tx_req_ip), 64'd0);
    chk({tag, "_srv_id"}, 64'(bus.tx_srv_id), 64'd0);
  endtask

  task automatic check_req(input string tag, input logic [31:0] xid,
                           input logic [31:0] yi, input logic [31:0] srv);
    chk({tag, "_type"},   64'(bus.tx_msg_type), 64'(DHCP_MSG_REQUEST));
    chk({tag, "_opt"},    64'(bus.tx_opt_pres), 64'(EXP_OPT_REQ));
    chk({tag, "_xid"},    64'(bus.tx_xid), 64'(xid));
    chk({tag, "_req_ip"}, 64'(bus.tx_req_ip), 64'(yi));
    chk({tag, "_srv_id"}, 64'(bus.tx_srv_id), 64'(srv));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tx_val"}, 64'(bus.tx_val), 64'd0);
    chk({tag, "_tx_xid"}, 64'(bus.tx_xid), 64'd0);
    chk({tag, "_tx_type"}, 64'(bus.tx_msg_type), 64'd0);
    chk({tag, "_tx_req_ip"}, 64'(bus.tx_req_ip), 64'd0);
    chk({tag, "_tx_srv_id"}, 64'(bus.tx_srv_id), 64'd0);
    chk({tag, "_tx_opt"}, 64'(bus.tx_opt_pres), 64'd0);
    chk({tag, "_ip_addr"}, 64'(ip_addr), 64'd0);
    chk({tag, "_status"}, 64'({ready, fail, busy}), 64'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, stray;
    logic [31:0] x1, yi, srv, yi2;

    bus.tx_done = 1'b0;
    bus.rx_val = 1'b0;
    bus.rx_msg_type = '0;
    bus.rx_xid = '0;
    bus.rx_yiaddr = '0;
    bus.rx_srv_id = '0;

    repeat (3) tick();
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    tick();

    // normal exchange with ignored noise in OFFER_WAIT
    start_pulse();
    wait_tx(10, n);
    chk("start_latency", 64'(n + 1), 64'd2);
    check_disc("n_disc");
    chk("n_busy", 64'({busy, ready, fail}), 64'b100);
    x1 = bus.tx_xid;
    do_tx_done($urandom_range(0, 3));
    start_pulse();
    send_rx(DHCP_MSG_NAK, x1, $urandom, $urandom);
    send_rx(DHCP_MSG_OFFER, x1 ^ 32'h1, $urandom, $urandom);
    tick();
    chk("n_noise_no_tx", 64'(bus.tx_val), 64'd0);
    chk("n_noise_disc_cnt", 64'(n_disc), 64'd1);
    srv = $urandom;
    send_rx(DHCP_MSG_OFFER, x1, YI, srv);
    wait_tx(3, n);
    chk("n_req_latency", 64'(n), 64'd1);
    check_req("n_req", x1, YI, srv);
    do_tx_done($urandom_range(0, 3));
    send_rx(DHCP_MSG_ACK, x1 ^ 32'h8000_0000, YI, srv);
    chk("n_bad_ack_ready", 64'(ready), 64'd0);
    send_rx(DHCP_MSG_ACK, x1, YI, srv);
    chk("n_bound", 64'({ready, fail, busy}), 64'b100);
    chk("n_ip_addr", 64'(ip_addr), 64'(YI));
    send_rx(DHCP_MSG_OFFER, x1, $urandom, $urandom);
    tick();
    chk("n_bound_rx_ignored", 64'({ready, busy, bus.tx_val}), 64'b100);

    // mismatched xid then timeout retransmission; retries run out to FAIL
    base = n_disc;
    start_pulse();
    chk("m_restart_clears", 64'({ready, ip_addr}), 64'd0);
    wait_tx(3, n);
    chk("m_disc_latency", 64'(n), 64'd1);
    x1 = bus.tx_xid;
    do_tx_done($urandom_range(0, 3));
    repeat (5) tick();
    send_rx(DHCP_MSG_OFFER, x1 ^ 32'h1, $urandom, $urandom);
    wait_tx(T + 10, n);
    chk("m_timeout_cycles", 64'(n), 64'(T - 5));
    check_disc("m_redisc");
    chk("m_new_xid", 64'(bus.tx_xid != x1), 64'd1);
    do_tx_done(0);
    wait_tx(T + 10, n);
    chk("r_timeout_cycles", 64'(n), 64'(T + 1));
    check_disc("r_disc3");
    do_tx_done($urandom_range(0, 3));
    stray = 0;
    for (int i = 0; i < int'(T) + 5; i++) begin
      tick();
      if (bus.tx_val) stray++;
    end
    chk("r_no_extra_tx", 64'(stray), 64'd0);
    chk("r_disc_count", 64'(n_disc - base), 64'(NRET));
    chk("r_fail_state", 64'({fail, busy, ready}), 64'b100);

    // NAK in ACK_WAIT restarts discovery
    start_pulse();
    chk("k_fail_cleared", 64'({fail, busy}), 64'b01);
    wait_tx(3, n);
    x1 = bus.tx_xid;
    do_tx_done($urandom_range(0, 3));
    yi = $urandom;
    srv = $urandom;
    send_rx(DHCP_MSG_OFFER, x1, yi, srv);
    wait_tx(3, n);
    check_req("k_req", x1, yi, srv);
    do_tx_done($urandom_range(0, 3));
    repeat ($urandom_range(1, 20)) tick();
    send_rx(DHCP_MSG_NAK, x1, $urandom, $urandom);
    wait_tx(2, n);
    chk("k_nak_latency", 64'(n), 64'd1);
    check_disc("k_disc");
    chk("k_fresh_xid", 64'(bus.tx_xid != x1), 64'd1);
    chk("k_ready", 64'(ready), 64'd0);

    // matching OFFER on the exact timeout cycle
    x1 = bus.tx_xid;
    base = n_disc;
    do_tx_done(0);
    repeat (T - 1) tick();
    yi = $urandom;
    srv = $urandom;
    send_rx(DHCP_MSG_OFFER, x1, yi, srv);
    wait_tx(3, n);
    chk("c_latency", 64'(n), 64'd1);
    check_req("c_req", x1, yi, srv);
    chk("c_no_disc", 64'(n_disc), 64'(base));

    // async reset while in ACK_WAIT
    do_tx_done(1);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    tick();
    chk("rst_hold_busy", 64'(busy), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    start_pulse();
    wait_tx(3, n);
    chk("rst_disc_latency", 64'(n), 64'd1);
    check_disc("rst_disc");

    // randomized full exchanges
    for (int it = 0; it < 4; it++) begin
      x1 = bus.tx_xid;
      do_tx_done($urandom_range(0, 3));
      repeat ($urandom_range(0, T - 2)) tick();
      yi = $urandom;
      srv = $urandom;
      send_rx(DHCP_MSG_OFFER, x1, yi, srv);
      wait_tx(3, n);
      check_req("x_req", x1, yi, srv);
      do_tx_done($urandom_range(0, 3));
      repeat ($urandom_range(0, T - 2)) tick();
      yi2 = $urandom;
      send_rx(DHCP_MSG_ACK, x1, yi2, srv);
      chk("x_ready", 64'({ready, busy}), 64'b10);
      chk("x_ip_addr", 64'(ip_addr), 64'(yi2));
      repeat ($urandom_range(0, 5)) tick();
      start_pulse();
      wait_tx(3, n);
      check_disc("x_disc");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
